// File: rtl/led_pattern_gen_if.sv
// Config write port for led_pattern_gen: one channel's mode/divide per accepted beat.
// Latency: n/a (signal bundle only).
// Backpressure: master holds cfg_valid and the payload until it sees cfg_ready at a clock edge.
//
// Signals:
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  write can be accepted this edge
//   cfg_ch     master->slave  target channel index
//   cfg_mode   master->slave  00 OFF, 01 ON, 10 BLINK, 11 BREATHE
//   cfg_div    master->slave  ticks per BLINK half-period / per BREATHE level step
interface led_pattern_gen_if #(
   parameter int DIV_BITS = 16
) ();
   logic                cfg_valid;
   logic                cfg_ready;
   logic [3:0]          cfg_ch;
   logic [1:0]          cfg_mode;
   logic [DIV_BITS-1:0] cfg_div;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_mode,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_mode,
      input  cfg_div,
      output cfg_ready
   );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler tick, per-channel OFF/ON/BLINK/BREATHE.
// Latency: config visible on led_out one clk after the accepting edge; led_out/tick_out registered.
// Backpressure: cfg_ready is 1 whenever out of reset; every write is taken in a single cycle.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active high
//   enable    1 = run; 0 = freeze every counter and hold led_out (config writes still land)
//   cfg       config write port (slave side of led_pattern_gen_if)
//   led_out   registered LED drive, bit n = channel n
//   tick_out  one-clk pulse following each prescaler wrap
module led_pattern_gen #(
   parameter int NUM_CH        = 4,
   parameter int PRESCALE      = 32000,
   parameter int PRESCALE_BITS = 15,
   parameter int DIV_BITS      = 16,
   parameter int PWM_BITS      = 8,
   parameter int DEFAULT_DIV   = 250
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   led_pattern_gen_if.slave    cfg,
   output logic [NUM_CH-1:0]   led_out,
   output logic                tick_out
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   localparam logic [PRESCALE_BITS-1:0] PRE_LAST = PRESCALE_BITS'(PRESCALE - 1);
   localparam logic [DIV_BITS-1:0]      DIV_RST  = DIV_BITS'(DEFAULT_DIV);
   localparam logic [DIV_BITS-1:0]      DIV_ONE  = DIV_BITS'(1);
   localparam logic [PWM_BITS-1:0]      LVL_MAX  = '1;
   localparam logic [PWM_BITS-1:0]      LVL_ONE  = PWM_BITS'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PRESCALE_BITS-1:0] pre_q, pre_d;
   logic [PWM_BITS-1:0]      pwm_q, pwm_d;
   logic                     tick_q, tick_d;
   logic                     rdy_q, rdy_d;
   logic [NUM_CH-1:0]        led_q, led_d;

   mode_e                    mode_q  [NUM_CH];
   mode_e                    mode_d  [NUM_CH];
   logic [DIV_BITS-1:0]      div_q   [NUM_CH];
   logic [DIV_BITS-1:0]      div_d   [NUM_CH];
   logic [DIV_BITS-1:0]      cnt_q   [NUM_CH];
   logic [DIV_BITS-1:0]      cnt_d   [NUM_CH];
   logic [PWM_BITS-1:0]      lvl_q   [NUM_CH];
   logic [PWM_BITS-1:0]      lvl_d   [NUM_CH];
   logic                     down_q  [NUM_CH];   // 1 = BREATHE level currently ramping down
   logic                     down_d  [NUM_CH];

   // ------------------------------------------------------------------
   // Shared timing and write decode
   // ------------------------------------------------------------------
   logic                wrap;     // internal tick: the edge at which the prescaler wraps
   logic                accept;
   logic [DIV_BITS-1:0] wr_div;
   mode_e               wr_mode;

   assign wrap    = enable && (pre_q == PRE_LAST);
   assign accept  = cfg.cfg_valid && rdy_q;
   // A zero divide would never match cnt==div-1 sensibly; treat it as the fastest rate.
   assign wr_div  = (cfg.cfg_div == '0) ? DIV_ONE : cfg.cfg_div;
   assign wr_mode = mode_e'(cfg.cfg_mode);

   assign cfg.cfg_ready = rdy_q;
   assign led_out       = led_q;
   assign tick_out      = tick_q;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      pre_d  = pre_q;
      pwm_d  = pwm_q;
      tick_d = 1'b0;
      rdy_d  = 1'b1;
      led_d  = led_q;
      mode_d = mode_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      down_d = down_q;

      if (enable) begin
         pre_d  = wrap ? '0 : pre_q + 1'b1;
         tick_d = wrap;
         pwm_d  = pwm_q + 1'b1;
      end

      for (int n = 0; n < NUM_CH; n++) begin
         // Out-of-range channel indices simply never match here, so such
         // writes are accepted and dropped.
         if (accept && (cfg.cfg_ch == 4'(n))) begin
            // A write restarts the channel from a clean phase; any tick
            // landing on the same edge is deliberately lost for this channel.
            mode_d[n] = wr_mode;
            div_d[n]  = wr_div;
            cnt_d[n]  = '0;
            lvl_d[n]  = '0;
            down_d[n] = 1'b0;
            led_d[n]  = 1'b0;
         end else if (enable) begin
            case (mode_q[n])
               MODE_OFF: led_d[n] = 1'b0;
               MODE_ON:  led_d[n] = 1'b1;
               MODE_BLINK: begin
                  // led_q itself is the blink phase; it only moves on a divided tick.
                  if (wrap) begin
                     if (cnt_q[n] == div_q[n] - 1'b1) begin
                        cnt_d[n] = '0;
                        led_d[n] = ~led_q[n];
                     end else begin
                        cnt_d[n] = cnt_q[n] + 1'b1;
                     end
                  end
               end
               MODE_BREATHE: begin
                  // PWM compare runs every clk against the level held this cycle.
                  led_d[n] = (pwm_q < lvl_q[n]);
                  if (wrap) begin
                     if (cnt_q[n] == div_q[n] - 1'b1) begin
                        cnt_d[n] = '0;
                        // Triangle ramp with no dwell: direction flips on the
                        // step that lands on an end value.
                        if (!down_q[n]) begin
                           lvl_d[n] = lvl_q[n] + 1'b1;
                           if (lvl_q[n] == LVL_MAX - LVL_ONE) begin
                              down_d[n] = 1'b1;
                           end
                        end else begin
                           lvl_d[n] = lvl_q[n] - 1'b1;
                           if (lvl_q[n] == LVL_ONE) begin
                              down_d[n] = 1'b0;
                           end
                        end
                     end else begin
                        cnt_d[n] = cnt_q[n] + 1'b1;
                     end
                  end
               end
               default: led_d[n] = 1'b0;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= '0;
         pwm_q  <= '0;
         tick_q <= 1'b0;
         rdy_q  <= 1'b0;
         led_q  <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            mode_q[n] <= MODE_OFF;
            div_q[n]  <= DIV_RST;
            cnt_q[n]  <= '0;
            lvl_q[n]  <= '0;
            down_q[n] <= 1'b0;
         end
      end else begin
         pre_q  <= pre_d;
         pwm_q  <= pwm_d;
         tick_q <= tick_d;
         rdy_q  <= rdy_d;
         led_q  <= led_d;
         for (int n = 0; n < NUM_CH; n++) begin
            mode_q[n] <= mode_d[n];
            div_q[n]  <= div_d[n];
            cnt_q[n]  <= cnt_d[n];
            lvl_q[n]  <= lvl_d[n];
            down_q[n] <= down_d[n];
         end
      end
   end

endmodule
